button_pulse_gen: RTL and testbench

Multi-channel pushbutton front end for the controller path.
- Synchronises raw board keys, debounces them and emits single-cycle press pulses.
- Optionally auto-repeats those pulses while a key is held.
- Its pulse_out bits are the 1-cycle pulses consumed by controller logic and by led_on_pulse indicators.

---
 rtl/sudoku_ctrl_pkg.sv | 15 +
 rtl/button_channel.sv | 118 +++++++++++
 rtl/button_pulse_gen.sv | 35 +++
 tb/tb_button_pulse_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sudoku_ctrl_pkg.sv
// Shared controller-path definitions: repeat FSM encoding and 50 MHz timing constants.
package sudoku_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int HOLD_500MS    = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

endpackage

// File: rtl/button_channel.sv
// One key: 2-FF sync, debounce, press detect and auto-repeat FSM with registered outputs.
module button_channel
  import sudoku_ctrl_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic clk,
  input  logic reset_fixed,
  input  logic btn_raw,
  output logic level_out,
  output logic pulse_out
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic             RELEASED  = (ACTIVE_LOW != 0);

  logic             sync1, sync2, pressed;
  logic             stable;
  logic [DB_W-1:0]  db_cnt;
  logic             press_now, rel_now, fire, pulse_next;
  rpt_state_e       state, state_next;
  logic [REP_W-1:0] rep_cnt, rep_cnt_next;

  always_ff @(posedge clk or negedge reset_fixed) begin
    if (!reset_fixed) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ RELEASED;

  always_ff @(posedge clk or negedge reset_fixed) begin
    if (!reset_fixed) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (pressed != stable) begin
      if (db_cnt == DB_LAST) begin
        stable <= ~stable;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // level_out lags stable by one flop, so their disagreement marks the edge being emitted.
  assign press_now = stable & ~level_out;
  assign rel_now   = ~stable & level_out;

  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    fire         = 1'b0;
    if (rel_now) begin
      state_next   = IDLE;
      rep_cnt_next = '0;
    end else if (press_now) begin
      if (REPEAT_EN != 0) state_next = HOLD;
      rep_cnt_next = '0;
    end else begin
      case (state)
        HOLD: begin
          if (rep_cnt == HOLD_LAST) begin
            fire         = 1'b1;
            rep_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rep_cnt_next = rep_cnt + REP_W'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt == REP_LAST) begin
            fire         = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + REP_W'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
    pulse_next = press_now | fire;
  end

  always_ff @(posedge clk or negedge reset_fixed) begin
    if (!reset_fixed) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      state     <= state_next;
      rep_cnt   <= rep_cnt_next;
      level_out <= stable;
      pulse_out <= pulse_next;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Multi-channel pushbutton front end: independent debounced press/repeat pulse channels.
module button_pulse_gen
  import sudoku_ctrl_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic                 clk,
  input  logic                 reset_fixed,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] level_out,
  output logic [N_BUTTONS-1:0] pulse_out
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset_fixed (reset_fixed),
      .btn_raw     (btn_raw[i]),
      .level_out   (level_out[i]),
      .pulse_out   (pulse_out[i])
    );
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen (debounce 4, hold 10, repeat 3, active-low keys).
module tb_button_pulse_gen;

  logic       clk = 1'b0;
  logic       reset_fixed;
  logic [3:0] btn_raw, btn_nr;
  logic [3:0] level_out, pulse_out, level_nr, pulse_nr;
  int         ncmp = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  button_pulse_gen #(
    .N_BUTTONS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .reset_fixed(reset_fixed), .btn_raw(btn_raw),
    .level_out(level_out), .pulse_out(pulse_out)
  );

  button_pulse_gen #(
    .N_BUTTONS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(0), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut_nr (
    .clk(clk), .reset_fixed(reset_fixed), .btn_raw(btn_nr),
    .level_out(level_nr), .pulse_out(pulse_nr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // After driving at edge+1, tick i lands just past the edge at which level_out/pulse_out
  // reflect the (i-1)th edge after the first sampling edge; press pulses appear at tick 7.
  initial begin
    reset_fixed = 1'b0;
    btn_raw     = 4'hF;
    btn_nr      = 4'hF;
    #2;
    chk("reset level", level_out, 4'h0);
    chk("reset pulse", pulse_out, 4'h0);
    tick();
    tick();
    chk("reset level clk", level_out, 4'h0);
    chk("reset nr level", level_nr, 4'h0);
    #1 reset_fixed = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("idle level", level_out, 4'h0);
    chk("idle pulse", pulse_out, 4'h0);

    // Clean press on key 0, held 8 cycles.
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("press lvl t%0d", i), level_out, (i >= 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("press pls t%0d", i), pulse_out, (i == 7) ? 4'b0001 : 4'b0000);
    end
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("rel lvl t%0d", i), level_out, (i < 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("rel pls t%0d", i), pulse_out, 4'b0000);
    end

    // Bounce on key 1: 3 low, 1 high, 3 low, high.
    for (int i = 1; i <= 18; i++) begin
      btn_raw[1] = !((i <= 3) || (i >= 5 && i <= 7));
      tick();
      chk($sformatf("bounce lvl t%0d", i), level_out, 4'b0000);
      chk($sformatf("bounce pls t%0d", i), pulse_out, 4'b0000);
    end
    btn_raw[1] = 1'b1;

    // Hold key 2 for 30 cycles: pulses at P, P+10, then every 3.
    btn_raw[2] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk($sformatf("hold lvl t%0d", i), level_out,
          (i >= 7 && i < 37) ? 4'b0100 : 4'b0000);
      chk($sformatf("hold pls t%0d", i), pulse_out,
          (i == 7 || (i >= 17 && i <= 35 && (i - 17) % 3 == 0)) ? 4'b0100 : 4'b0000);
      if (i == 30) btn_raw[2] = 1'b1;
    end

    // Key 3: release falls on the cycle the second repeat is due, then a fresh press.
    btn_raw[3] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk($sformatf("coll lvl t%0d", i), level_out,
          ((i >= 7 && i < 20) || (i >= 32 && i < 40)) ? 4'b1000 : 4'b0000);
      chk($sformatf("coll pls t%0d", i), pulse_out,
          (i == 7 || i == 17 || i == 32) ? 4'b1000 : 4'b0000);
      if (i == 13) btn_raw[3] = 1'b1;
      if (i == 25) btn_raw[3] = 1'b0;
      if (i == 33) btn_raw[3] = 1'b1;
    end

    // All keys at once, with and without auto-repeat.
    btn_raw = 4'b0000;
    btn_nr  = 4'b0000;
    for (int i = 1; i <= 35; i++) begin
      tick();
      chk($sformatf("par lvl t%0d", i), level_out, (i >= 7 && i < 27) ? 4'hF : 4'h0);
      chk($sformatf("par pls t%0d", i), pulse_out,
          (i == 7 || i == 17 || i == 20 || i == 23 || i == 26) ? 4'hF : 4'h0);
      chk($sformatf("nr lvl t%0d", i), level_nr, (i >= 7 && i < 27) ? 4'hF : 4'h0);
      chk($sformatf("nr pls t%0d", i), pulse_nr, (i == 7) ? 4'hF : 4'h0);
      if (i == 20) begin
        btn_raw = 4'hF;
        btn_nr  = 4'hF;
      end
    end

    // Reset while key 0 is held in REPEAT, right on a repeat pulse.
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 17; i++) tick();
    chk("pre-reset pulse", pulse_out, 4'b0001);
    #2 reset_fixed = 1'b0;
    #1;
    chk("async reset level", level_out, 4'h0);
    chk("async reset pulse", pulse_out, 4'h0);
    tick();
    tick();
    chk("in reset level", level_out, 4'h0);
    #1 reset_fixed = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk($sformatf("rst lvl t%0d", i), level_out, (i >= 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("rst pls t%0d", i), pulse_out,
          (i == 7 || i == 17 || i == 20) ? 4'b0001 : 4'b0000);
    end
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
